// File: rtl/mem_wb_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage_pkg
// Description : Shared constants for the MEM->WB stage: reset/write levels,
//               bus widths, load-type codes and WB FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_wb_stage_pkg;

  localparam logic        RST_ENABLE   = 1'b1;
  localparam logic        WR_ENABLE    = 1'b1;
  localparam int          REG_BUS      = 32;
  localparam int          REG_ADDR_BUS = 5;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

  // Load-type codes as presented by MEM; codes 5..7 are reserved (handled as LW)
  localparam logic [2:0] LD_LB  = 3'd0;
  localparam logic [2:0] LD_LBU = 3'd1;
  localparam logic [2:0] LD_LH  = 3'd2;
  localparam logic [2:0] LD_LHU = 3'd3;
  localparam logic [2:0] LD_LW  = 3'd4;

  // WB FSM state encoding
  localparam logic [0:0] WB_IDLE = 1'b0;
  localparam logic [0:0] WB_WAIT = 1'b1;

endpackage : mem_wb_stage_pkg
`default_nettype wire

// File: rtl/mem_wb_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module      : wb_load_align
// Description : Combinational load-data aligner. Selects the byte/halfword
//               lane from a raw memory word, sign/zero-extends it, and flags
//               misaligned halfword/word accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_load_align
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = REG_BUS
) (
  input  logic [2:0]        ld_type_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] data_o,
  output logic              misalign_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Byte lane is the full offset, halfword lane is offset bit 1
  assign w_byte = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign w_half = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

  // Extend the selected lane and check natural alignment
  always_comb begin
    data_o     = rdata_i;
    misalign_o = 1'b0;
    case (ld_type_i)
      LD_LB: begin
        data_o = {{(DATA_W-8){w_byte[7]}}, w_byte};
      end
      LD_LBU: begin
        data_o = {{(DATA_W-8){1'b0}}, w_byte};
      end
      LD_LH: begin
        data_o     = {{(DATA_W-16){w_half[15]}}, w_half};
        misalign_o = addr_lo_i[0];
      end
      LD_LHU: begin
        data_o     = {{(DATA_W-16){1'b0}}, w_half};
        misalign_o = addr_lo_i[0];
      end
      default: begin
        // LW and reserved codes: whole word, must be word aligned
        data_o     = rdata_i;
        misalign_o = (addr_lo_i != 2'b00);
      end
    endcase
  end

endmodule : wb_load_align
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage
// Description : MEM->WB pipeline stage and sole driver of the register-file
//               write port. Retires ALU results after one cycle, waits on a
//               variable-latency data memory for loads (stalling upstream),
//               aligns/extends load data and reports misalign/timeout errors.
//               Optional macro WB_PERF_CNT_EN adds retire/stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W  = REG_BUS,
  parameter int RADDR_W = REG_ADDR_BUS,
  parameter int LAT_MAX = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               mem_valid,
  input  logic               mem_we,
  input  logic [RADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0]  mem_wdata,
  input  logic               mem_is_load,
  input  logic [2:0]         mem_ld_type,
  input  logic [1:0]         mem_addr_lo,
  input  logic               dmem_rvalid,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic               stall_req,
  output logic               wb_we,
  output logic [RADDR_W-1:0] wb_waddr,
  output logic [DATA_W-1:0]  wb_wdata,
  output logic               wb_retire,
  output logic               wb_err
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]        perf_retired,
  output logic [31:0]        perf_stall
`endif
);

  localparam int CNT_W = (LAT_MAX < 2) ? 1 : $clog2(LAT_MAX + 1);

  logic [0:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               ld_we_q;
  logic [RADDR_W-1:0] ld_waddr_q;
  logic [2:0]         ld_type_q;
  logic [1:0]         ld_addr_lo_q;
  logic               w_capture;

  logic               wb_we_q, wb_we_d;
  logic [RADDR_W-1:0] wb_waddr_q, wb_waddr_d;
  logic [DATA_W-1:0]  wb_wdata_q, wb_wdata_d;
  logic               wb_retire_q, wb_retire_d;
  logic               wb_err_q, wb_err_d;

  logic [2:0]         w_al_type;
  logic [1:0]         w_al_lo;
  logic [DATA_W-1:0]  w_ld_data;
  logic               w_misalign;
  logic               w_timeout;

  // In WAIT the aligner works on the captured load, in IDLE on MEM directly
  assign w_al_type = (state_q == WB_WAIT) ? ld_type_q    : mem_ld_type;
  assign w_al_lo   = (state_q == WB_WAIT) ? ld_addr_lo_q : mem_addr_lo;

  wb_load_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .ld_type_i  (w_al_type),
    .addr_lo_i  (w_al_lo),
    .rdata_i    (dmem_rdata),
    .data_o     (w_ld_data),
    .misalign_o (w_misalign)
  );

  // Timeout fires in the WAIT cycle where the counter would reach LAT_MAX
  assign w_timeout = (state_q == WB_WAIT) && !dmem_rvalid &&
                     (cnt_q == CNT_W'(LAT_MAX - 1));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) state_q <= WB_IDLE;
    else                   state_q <= state_d;
  end

  // FSM next state: enter WAIT on an aligned load without same-cycle data
  always_comb begin
    state_d = state_q;
    case (state_q)
      WB_IDLE: begin
        if (mem_valid && mem_is_load && !w_misalign && !dmem_rvalid)
          state_d = WB_WAIT;
      end
      WB_WAIT: begin
        if (dmem_rvalid || w_timeout) state_d = WB_IDLE;
      end
      default: state_d = WB_IDLE;
    endcase
    if (flush) state_d = WB_IDLE;
  end

  // FSM outputs: stall, write-port next values, counter and capture strobe
  always_comb begin
    stall_req   = 1'b0;
    w_capture   = 1'b0;
    cnt_d       = cnt_q;
    wb_we_d     = 1'b0;
    wb_retire_d = 1'b0;
    wb_err_d    = 1'b0;
    wb_waddr_d  = wb_waddr_q;
    wb_wdata_d  = wb_wdata_q;
    if (flush) begin
      cnt_d = '0;
    end else begin
      case (state_q)
        WB_IDLE: begin
          if (mem_valid) begin
            if (!mem_is_load) begin
              wb_retire_d = 1'b1;
              wb_we_d     = (mem_we == WR_ENABLE) && (mem_waddr != '0);
              wb_waddr_d  = mem_waddr;
              wb_wdata_d  = mem_wdata;
            end else if (w_misalign) begin
              wb_err_d = 1'b1;
            end else if (dmem_rvalid) begin
              wb_retire_d = 1'b1;
              wb_we_d     = (mem_we == WR_ENABLE) && (mem_waddr != '0);
              wb_waddr_d  = mem_waddr;
              wb_wdata_d  = w_ld_data;
            end else begin
              stall_req = 1'b1;
              w_capture = 1'b1;
              cnt_d     = '0;
            end
          end
        end
        WB_WAIT: begin
          if (dmem_rvalid) begin
            wb_retire_d = 1'b1;
            wb_we_d     = ld_we_q && (ld_waddr_q != '0);
            wb_waddr_d  = ld_waddr_q;
            wb_wdata_d  = w_ld_data;
            cnt_d       = '0;
          end else if (w_timeout) begin
            stall_req = 1'b1;
            wb_err_d  = 1'b1;
            cnt_d     = '0;
          end else begin
            stall_req = 1'b1;
            cnt_d     = cnt_q + CNT_W'(1);
          end
        end
        default: cnt_d = '0;
      endcase
    end
  end

  // Write-port registers; pulses self-clear, address/data hold when idle
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      cnt_q       <= '0;
      wb_we_q     <= 1'b0;
      wb_waddr_q  <= '0;
      wb_wdata_q  <= ZERO_WORD[DATA_W-1:0];
      wb_retire_q <= 1'b0;
      wb_err_q    <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      wb_we_q     <= wb_we_d;
      wb_waddr_q  <= wb_waddr_d;
      wb_wdata_q  <= wb_wdata_d;
      wb_retire_q <= wb_retire_d;
      wb_err_q    <= wb_err_d;
    end
  end

  // Capture the pending load's destination and format when entering WAIT
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      ld_we_q      <= 1'b0;
      ld_waddr_q   <= '0;
      ld_type_q    <= LD_LW;
      ld_addr_lo_q <= 2'b00;
    end else if (w_capture) begin
      ld_we_q      <= mem_we;
      ld_waddr_q   <= mem_waddr;
      ld_type_q    <= mem_ld_type;
      ld_addr_lo_q <= mem_addr_lo;
    end
  end

  assign wb_we     = wb_we_q;
  assign wb_waddr  = wb_waddr_q;
  assign wb_wdata  = wb_wdata_q;
  assign wb_retire = wb_retire_q;
  assign wb_err    = wb_err_q;

`ifdef WB_PERF_CNT_EN
  logic [31:0] perf_retired_q;
  logic [31:0] perf_stall_q;

  // Free-running wrap-around counters of retirements and stall cycles
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      perf_retired_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (wb_retire_q) perf_retired_q <= perf_retired_q + 32'd1;
      if (stall_req)   perf_stall_q   <= perf_stall_q + 32'd1;
    end
  end

  assign perf_retired = perf_retired_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule : mem_wb_stage
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_stage
// Description : Self-checking bench for mem_wb_stage. A transaction-level
//               driver predicts each write-port event into a scoreboard
//               queue; a negedge monitor pops and compares every event.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

  localparam int LAT_MAX = 15;

  typedef struct {
    bit          err;
    bit          retire;
    bit          we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_we = 1'b0;
  logic [4:0]  mem_waddr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_is_load = 1'b0;
  logic [2:0]  mem_ld_type = '0;
  logic [1:0]  mem_addr_lo = '0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        stall_req;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        wb_retire;
  logic        wb_err;
`ifdef WB_PERF_CNT_EN
  logic [31:0] perf_retired;
  logic [31:0] perf_stall;
  int unsigned exp_ret_cnt = 0;
  int unsigned exp_stall_cnt = 0;
`endif

  int          checks = 0;
  int          failures = 0;
  exp_t        sb[$];
  logic [4:0]  last_waddr = '0;
  logic [31:0] last_wdata = '0;

  mem_wb_stage #(.DATA_W(32), .RADDR_W(5), .LAT_MAX(LAT_MAX)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .mem_valid   (mem_valid),
    .mem_we      (mem_we),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .mem_is_load (mem_is_load),
    .mem_ld_type (mem_ld_type),
    .mem_addr_lo (mem_addr_lo),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata),
    .stall_req   (stall_req),
    .wb_we       (wb_we),
    .wb_waddr    (wb_waddr),
    .wb_wdata    (wb_wdata),
    .wb_retire   (wb_retire),
    .wb_err      (wb_err)
`ifdef WB_PERF_CNT_EN
    ,
    .perf_retired (perf_retired),
    .perf_stall   (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // Reference load extraction, straight from the lane/extension rules
  function automatic logic [31:0] ref_load(input logic [2:0] t, input logic [1:0] lo,
                                           input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * lo)) & 32'hFF;
    h = (w >> (16 * lo[1])) & 32'hFFFF;
    case (t)
      3'd0:    return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return b;
      3'd2:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'd3:    return h;
      default: return w;
    endcase
  endfunction

  function automatic bit ref_misal(input logic [2:0] t, input logic [1:0] lo);
    if (t == 3'd0 || t == 3'd1) return 1'b0;
    if (t == 3'd2 || t == 3'd3) return lo[0];
    return lo != 2'b00;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush       = 1'b0;
    mem_valid   = 1'b0;
    mem_is_load = 1'b0;
    dmem_rvalid = 1'b0;
  endtask

  task automatic check_stall(input bit exp, input string name);
    #2;
    checks++;
    if (stall_req !== exp) begin
      failures++;
      $display("FAIL %s: stall_req=%0b expected=%0b at %0t", name, stall_req, exp, $time);
    end
`ifdef WB_PERF_CNT_EN
    if (exp) exp_stall_cnt++;
`endif
  endtask

  task automatic push_retire(input bit we, input logic [4:0] wa, input logic [31:0] d);
    exp_t e;
    e.err = 0; e.retire = 1; e.we = we && (wa != 5'd0); e.waddr = wa; e.wdata = d;
    sb.push_back(e);
    last_waddr = wa;
    last_wdata = d;
`ifdef WB_PERF_CNT_EN
    exp_ret_cnt++;
`endif
  endtask

  task automatic push_err();
    exp_t e;
    e.err = 1; e.retire = 0; e.we = 0; e.waddr = last_waddr; e.wdata = last_wdata;
    sb.push_back(e);
  endtask

  task automatic do_alu(input bit we, input logic [4:0] wa, input logic [31:0] d, input bit fl);
    flush = fl; mem_valid = 1; mem_is_load = 0; mem_we = we; mem_waddr = wa; mem_wdata = d;
    mem_ld_type = 3'($urandom); mem_addr_lo = 2'($urandom);
    dmem_rvalid = 1'($urandom); dmem_rdata = $urandom;
    check_stall(0, "alu_stall");
    if (!fl) push_retire(we, wa, d);
    tick();
    idle_inputs();
  endtask

  // d = cycle index of rvalid (0 = same cycle); d > LAT_MAX means never
  task automatic do_load(input logic [2:0] t, input logic [1:0] lo, input int d,
                         input bit we, input logic [4:0] wa, input logic [31:0] word);
    mem_valid = 1; mem_is_load = 1; mem_ld_type = t; mem_addr_lo = lo;
    mem_we = we; mem_waddr = wa; mem_wdata = $urandom; flush = 0;
    dmem_rvalid = (d == 0) ? 1'b1 : 1'($urandom);
    dmem_rdata  = (d == 0) ? word : $urandom;
    if (ref_misal(t, lo)) begin
      check_stall(0, "misal_stall");
      push_err();
      tick();
      idle_inputs();
      return;
    end
    dmem_rvalid = (d == 0);
    if (d == 0) begin
      check_stall(0, "load0_stall");
      push_retire(we, wa, ref_load(t, lo, word));
      tick();
      idle_inputs();
      return;
    end
    check_stall(1, "load_cap_stall");
    tick();
    for (int k = 1; k <= LAT_MAX; k++) begin
      // MEM fields are scrambled while waiting; the captured copy must be used
      mem_valid = 1'($urandom); mem_is_load = 1'($urandom); mem_we = 1'($urandom);
      mem_waddr = 5'($urandom); mem_ld_type = 3'($urandom); mem_addr_lo = 2'($urandom);
      dmem_rvalid = (k == d);
      dmem_rdata  = (k == d) ? word : $urandom;
      check_stall(k != d, "load_wait_stall");
      tick();
      if (k == d) break;
    end
    if (d > LAT_MAX) push_err();
    else             push_retire(we, wa, ref_load(t, lo, word));
    idle_inputs();
  endtask

  // Flush after k wait cycles, then a late rvalid that must be ignored
  task automatic do_flush_wait(input int k);
    mem_valid = 1; mem_is_load = 1; mem_ld_type = 3'd4; mem_addr_lo = 0;
    mem_we = 1; mem_waddr = 5'($urandom_range(1, 31)); dmem_rvalid = 0;
    flush = (k == 0);
    check_stall(k != 0, "flush_cap_stall");
    tick();
    if (k != 0) begin
      for (int i = 1; i < k; i++) begin
        check_stall(1, "flush_wait_stall");
        tick();
      end
      flush = 1; dmem_rvalid = 1'($urandom); dmem_rdata = $urandom;
      check_stall(0, "flush_cycle_stall");
      tick();
    end
    idle_inputs();
    dmem_rvalid = 1; dmem_rdata = $urandom;
    check_stall(0, "late_rvalid_stall");
    tick();
    idle_inputs();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write-port event must match the queue head
  always @(negedge clk) begin
    if (!rst && (wb_we || wb_retire || wb_err)) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event: we=%0b retire=%0b err=%0b waddr=%0d wdata=0x%08h expected=none",
                 wb_we, wb_retire, wb_err, wb_waddr, wb_wdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (wb_we !== e.we || wb_retire !== e.retire || wb_err !== e.err ||
            wb_waddr !== e.waddr || wb_wdata !== e.wdata) begin
          failures++;
          $display("FAIL wb_event: got we=%0b ret=%0b err=%0b wa=%0d wd=0x%08h expected we=%0b ret=%0b err=%0b wa=%0d wd=0x%08h",
                   wb_we, wb_retire, wb_err, wb_waddr, wb_wdata,
                   e.we, e.retire, e.err, e.waddr, e.wdata);
        end
      end
    end
  end

  initial begin
    logic [2:0] t;
    logic [1:0] lo;
    int kind;

    tick(); tick();
    rst = 0;
    #2;
    chk("reset_we", {31'd0, wb_we}, 32'd0);
    chk("reset_waddr", {27'd0, wb_waddr}, 32'd0);
    chk("reset_wdata", wb_wdata, 32'd0);
    chk("reset_retire", {31'd0, wb_retire}, 32'd0);
    chk("reset_err", {31'd0, wb_err}, 32'd0);
    chk("reset_stall", {31'd0, stall_req}, 32'd0);
    tick();

    // Reset in the middle of a wait: everything back to zero
    mem_valid = 1; mem_is_load = 1; mem_ld_type = 3'd4; mem_addr_lo = 0;
    mem_we = 1; mem_waddr = 5'd9; dmem_rvalid = 0;
    check_stall(1, "rstwait_cap_stall");
    tick();
    idle_inputs();
    tick();
    rst = 1;
    tick();
    rst = 0;
    #2;
    chk("midrst_we", {31'd0, wb_we}, 32'd0);
    chk("midrst_waddr", {27'd0, wb_waddr}, 32'd0);
    chk("midrst_wdata", wb_wdata, 32'd0);
    chk("midrst_retire", {31'd0, wb_retire}, 32'd0);
    chk("midrst_err", {31'd0, wb_err}, 32'd0);
    chk("midrst_stall", {31'd0, stall_req}, 32'd0);
    last_waddr = '0; last_wdata = '0;
`ifdef WB_PERF_CNT_EN
    exp_ret_cnt = 0; exp_stall_cnt = 0;
`endif
    tick();

    // Directed cases
    do_alu(1, 5'd5, 32'h1234_5678, 0);
    do_load(3'd0, 2'd3, 0, 1, 5'd7, 32'h80AA_BBCC);
    do_load(3'd1, 2'd3, 0, 1, 5'd8, 32'h80AA_BBCC);
    do_load(3'd4, 2'd0, 3, 1, 5'd10, 32'hDEAD_BEEF);
    do_load(3'd2, 2'd1, 0, 1, 5'd11, 32'h1111_2222);
    do_flush_wait(2);
    do_load(3'd4, 2'd0, LAT_MAX + 1, 1, 5'd12, 32'h0);
    do_load(3'd2, 2'd2, LAT_MAX, 1, 5'd13, 32'h9234_5678);
    do_alu(1, 5'd0, 32'hCAFE_F00D, 0);
    do_alu(1, 5'd14, 32'h0BAD_0BAD, 1);
    do_flush_wait(0);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1, 2, 3:
          do_alu(1'($urandom), ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom,
                 $urandom_range(0, 15) == 0);
        4, 5, 6: begin
          t = 3'($urandom);
          lo = 2'($urandom);
          if (t == 3'd2 || t == 3'd3) lo[0] = 1'b0;
          else if (t != 3'd0 && t != 3'd1) lo = 2'd0;
          do_load(t, lo, (kind == 6 && $urandom_range(0, 3) == 0) ? $urandom_range(LAT_MAX, LAT_MAX + 1)
                                                                 : $urandom_range(0, 5),
                  1'($urandom), 5'($urandom), $urandom);
        end
        7: begin
          t = 3'($urandom_range(2, 7));
          lo = (t == 3'd2 || t == 3'd3) ? {1'($urandom), 1'b1} : 2'($urandom_range(1, 3));
          do_load(t, lo, 0, 1'($urandom), 5'($urandom), $urandom);
        end
        8: do_flush_wait($urandom_range(0, 4));
        default: begin
          dmem_rvalid = 1; dmem_rdata = $urandom;
          check_stall(0, "stray_rvalid_stall");
          tick();
          idle_inputs();
        end
      endcase
    end

    tick(); tick(); tick();
    chk("scoreboard_drained", sb.size(), 32'd0);
`ifdef WB_PERF_CNT_EN
    chk("perf_retired", perf_retired, exp_ret_cnt);
    chk("perf_stall", perf_stall, exp_stall_cnt);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mem_wb_stage
`default_nettype wire
